execute_stage: RTL and testbench

//  Execute stage downstream of iDecode in the LEGv8 datapath: accepts decoded operands and

---
 rtl/execute_stage.sv | 167 ++++++++++++++++
 tb/tb_execute_stage.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// LEGv8 execute stage: registered ALU result, branch target and control, with an
// iterative shift-add multiplier behind valid/ready handshakes on both sides.
`ifndef WORD
`define WORD 64
`endif

module execute_stage #(
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [`WORD-1:0] cur_pc,
    input  logic [`WORD-1:0] read_data1,
    input  logic [`WORD-1:0] read_data2,
    input  logic [`WORD-1:0] sign_extended_output,
    input  logic [10:0]      opcode,
    input  logic [1:0]       alu_op,
    input  logic             alu_src,
    input  logic             branch,
    input  logic             uncondbranch,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [`WORD-1:0] alu_result,
    output logic             zero,
    output logic [`WORD-1:0] branch_target,
    output logic             pc_src,
    output logic [`WORD-1:0] write_data_out,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o
);
    localparam int W     = `WORD;
    localparam int STEPS = W / MUL_STEP;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_next;

    logic [W-1:0]  operand_b;
    logic [W-1:0]  alu_value;
    logic [W-1:0]  branch_sum;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [CW-1:0] count;
    logic          branch_q;
    logic          uncond_q;
    logic          is_mul;
    logic          accept;
    logic          mul_done;

    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign operand_b  = alu_src ? sign_extended_output : read_data2;
    assign is_mul     = (alu_op == 2'b10) && (opcode == OPC_MUL);
    assign branch_sum = cur_pc + (sign_extended_output << 2);
    assign mul_done   = (state == MUL) && (count == CW'(STEPS - 1));

    // mul_a/mul_b are pre-shifted each step, so the low digit of mul_b always
    // pairs with A already scaled to that digit's weight.
    assign acc_next = acc + mul_a * W'(mul_b[MUL_STEP-1:0]);

    always_comb begin
        alu_value = '0;
        case (alu_op)
            2'b01: alu_value = operand_b;
            2'b10: begin
                case (opcode)
                    OPC_ADD: alu_value = read_data1 + operand_b;
                    OPC_SUB: alu_value = read_data1 - operand_b;
                    OPC_AND: alu_value = read_data1 & operand_b;
                    OPC_ORR: alu_value = read_data1 | operand_b;
                    default: alu_value = '0;
                endcase
            end
            default: alu_value = read_data1 + operand_b;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_mul) state_next = MUL;
            MUL:     if (mul_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output registers only load on accept or MUL completion, which keeps them
    // frozen while downstream stalls (accept is impossible then).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            alu_result     <= '0;
            zero           <= 1'b0;
            branch_target  <= '0;
            pc_src         <= 1'b0;
            write_data_out <= '0;
            mem_read_o     <= 1'b0;
            mem_write_o    <= 1'b0;
            mem_to_reg_o   <= 1'b0;
            reg_write_o    <= 1'b0;
            mul_a          <= '0;
            mul_b          <= '0;
            acc            <= '0;
            count          <= '0;
            branch_q       <= 1'b0;
            uncond_q       <= 1'b0;
        end else if (accept) begin
            branch_target  <= branch_sum;
            write_data_out <= read_data2;
            mem_read_o     <= mem_read;
            mem_write_o    <= mem_write;
            mem_to_reg_o   <= mem_to_reg;
            reg_write_o    <= reg_write;
            if (is_mul) begin
                mul_a      <= read_data1;
                mul_b      <= operand_b;
                acc        <= '0;
                count      <= '0;
                branch_q   <= branch;
                uncond_q   <= uncondbranch;
                out_valid  <= 1'b0;
                alu_result <= '0;
                zero       <= 1'b0;
                pc_src     <= 1'b0;
            end else begin
                alu_result <= alu_value;
                zero       <= (alu_value == '0);
                pc_src     <= uncondbranch | (branch & (alu_value == '0));
                out_valid  <= 1'b1;
            end
        end else if (state == MUL) begin
            acc   <= acc_next;
            mul_a <= mul_a << MUL_STEP;
            mul_b <= mul_b >> MUL_STEP;
            count <= count + CW'(1);
            if (mul_done) begin
                alu_result <= acc_next;
                zero       <= (acc_next == '0);
                pc_src     <= uncond_q | (branch_q & (acc_next == '0));
                out_valid  <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected results are queued as instructions
// are driven and popped when the stage presents a result.
`ifndef WORD
`define WORD 64
`endif

module tb_execute_stage;
    localparam int W = `WORD;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic [W-1:0] target;
        logic         pc_src;
        logic [W-1:0] wdata;
        logic [3:0]   ctrl;
    } res_t;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] imm;
        logic [10:0]  opc;
        logic [1:0]   aop;
        logic         asrc;
        logic         br;
        logic         ub;
        logic [3:0]   ctrl;
        string        name;
    } stim_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] cur_pc = '0;
    logic [W-1:0] read_data1 = '0;
    logic [W-1:0] read_data2 = '0;
    logic [W-1:0] sign_extended_output = '0;
    logic [10:0]  opcode = '0;
    logic [1:0]   alu_op = '0;
    logic         alu_src = 1'b0;
    logic         branch = 1'b0;
    logic         uncondbranch = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic         mem_to_reg = 1'b0;
    logic         reg_write = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] alu_result;
    logic         zero;
    logic [W-1:0] branch_target;
    logic         pc_src;
    logic [W-1:0] write_data_out;
    logic         mem_read_o;
    logic         mem_write_o;
    logic         mem_to_reg_o;
    logic         reg_write_o;

    res_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    execute_stage #(.MUL_STEP(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cur_pc(cur_pc), .read_data1(read_data1), .read_data2(read_data2),
        .sign_extended_output(sign_extended_output), .opcode(opcode), .alu_op(alu_op),
        .alu_src(alu_src), .branch(branch), .uncondbranch(uncondbranch),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
        .pc_src(pc_src), .write_data_out(write_data_out), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input string name, input logic [W-1:0] pc, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] imm, input logic [10:0] opc,
                                 input logic [1:0] aop, input logic asrc, input logic br,
                                 input logic ub, input logic [3:0] ctrl);
        stim_t s;
        s.name = name; s.pc = pc; s.a = a; s.b = b; s.imm = imm; s.opc = opc;
        s.aop = aop; s.asrc = asrc; s.br = br; s.ub = ub; s.ctrl = ctrl;
        return s;
    endfunction

    // Reference behaviour of one instruction, written from the ISA semantics.
    function automatic res_t model(input stim_t s);
        res_t         r;
        logic [W-1:0] bv;
        bv = s.asrc ? s.imm : s.b;
        if (s.aop == 2'b01)
            r.result = bv;
        else if (s.aop == 2'b10) begin
            if (s.opc == OPC_ADD)      r.result = s.a + bv;
            else if (s.opc == OPC_SUB) r.result = s.a - bv;
            else if (s.opc == OPC_AND) r.result = s.a & bv;
            else if (s.opc == OPC_ORR) r.result = s.a | bv;
            else if (s.opc == OPC_MUL) r.result = s.a * bv;
            else                       r.result = '0;
        end else
            r.result = s.a + bv;
        r.zero   = (r.result == '0);
        r.target = s.pc + {s.imm[W-3:0], 2'b00};
        r.pc_src = s.ub | (s.br & r.zero);
        r.wdata  = s.b;
        r.ctrl   = s.ctrl;
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.result = alu_result;
        r.zero   = zero;
        r.target = branch_target;
        r.pc_src = pc_src;
        r.wdata  = write_data_out;
        r.ctrl   = {mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o};
        return r;
    endfunction

    function automatic res_t pop_expected();
        res_t r;
        r = 'x;
        if (sb.size() > 0) r = sb.pop_front();
        return r;
    endfunction

    task automatic drive(input stim_t s);
        cur_pc = s.pc; read_data1 = s.a; read_data2 = s.b; sign_extended_output = s.imm;
        opcode = s.opc; alu_op = s.aop; alu_src = s.asrc; branch = s.br; uncondbranch = s.ub;
        {mem_read, mem_write, mem_to_reg, reg_write} = s.ctrl;
        in_valid = 1'b1;
        sb.push_back(model(s));
    endtask

    task automatic send(input stim_t s);
        int waited;
        waited = 0;
        @(negedge clk);
        drive(s);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s accept: in_ready=%0b required 1 within 100 cycles", s.name, in_ready);
            void'(sb.pop_back());
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_output(output int lat, output bit ready_seen);
        lat = 0;
        ready_seen = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_seen = 1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        res_t got;
        #12;
        got = observed();
        tests_run++;
        if (out_valid !== 1'b0 || got !== res_t'(0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: out_valid=%0b outputs=%h required 0", out_valid, got);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_alu();
        stim_t tbl[$];
        res_t  got, exp_r;
        int    lat;
        bit    rs;
        tbl.push_back(mk("add",     64'd0,     64'd10, 64'd20, 64'd0, OPC_ADD, 2'b10, 0, 0, 0, 4'b0001));
        tbl.push_back(mk("sub",     64'd4,     64'd30, 64'd30, 64'd1, OPC_SUB, 2'b10, 0, 0, 0, 4'b0001));
        tbl.push_back(mk("and",     64'd8,     64'hF0, 64'h3C, 64'd2, OPC_AND, 2'b10, 0, 0, 0, 4'b0001));
        tbl.push_back(mk("orr",     64'd12,    64'hF0, 64'h0F, 64'd3, OPC_ORR, 2'b10, 0, 0, 0, 4'b0001));
        tbl.push_back(mk("add_wrap", 64'd0, {W{1'b1}}, 64'd2, 64'd0, OPC_ADD, 2'b10, 0, 0, 0, 4'b0001));
        tbl.push_back(mk("bad_opc", 64'd20,    64'd5,  64'd6,  64'd0, 11'b11111111111, 2'b10, 0, 0, 0, 4'b0001));
        tbl.push_back(mk("aluop11", 64'd24,    64'd3,  64'd4,  64'd0, 11'd0,   2'b11, 0, 0, 0, 4'b0000));
        tbl.push_back(mk("ldur",    64'd28,    64'd16, 64'd0,  64'h40, 11'd0,  2'b00, 1, 0, 0, 4'b1011));
        tbl.push_back(mk("stur",    64'd32,    64'd8, 64'hDEAD, 64'd8, 11'd0,  2'b00, 1, 0, 0, 4'b0100));
        tbl.push_back(mk("cbz_take", 64'd16,   64'd9,  64'd0, -64'sd5, 11'd0,  2'b01, 0, 1, 0, 4'b0000));
        tbl.push_back(mk("cbz_skip", 64'd16,   64'd9,  64'd20, -64'sd5, 11'd0, 2'b01, 0, 1, 0, 4'b0000));
        tbl.push_back(mk("b_uncond", 64'h100,  64'd0,  64'd7,  64'd3,  11'd0,  2'b01, 0, 0, 1, 4'b0000));
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_output(lat, rs);
            got = observed();
            exp_r = pop_expected();
            tests_run++;
            if (!out_valid || lat != 0 || got !== exp_r) begin
                tests_failed++;
                $display("[TB] FAIL %s: latency %0d got %h required latency 0 %h", tbl[i].name, lat, got, exp_r);
            end
        end
    endtask

    task automatic test_mul();
        stim_t tbl[$];
        res_t  got, exp_r;
        int    lat;
        bit    rs;
        tbl.push_back(mk("mul_7x6",  64'd0, 64'd7, 64'd6, 64'd0, OPC_MUL, 2'b10, 0, 0, 0, 4'b0001));
        tbl.push_back(mk("mul_max2", 64'd4, {W{1'b1}}, 64'd2, 64'd0, OPC_MUL, 2'b10, 0, 0, 0, 4'b0001));
        tbl.push_back(mk("mul_zero", 64'd8, 64'd12345, 64'd0, 64'd1, OPC_MUL, 2'b10, 0, 1, 0, 4'b0001));
        tbl.push_back(mk("mul_rand", 64'd12, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0,
                         OPC_MUL, 2'b10, 0, 0, 0, 4'b0001));
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_output(lat, rs);
            got = observed();
            exp_r = pop_expected();
            tests_run++;
            if (!out_valid || lat != W / 4 || rs || got !== exp_r) begin
                tests_failed++;
                $display("[TB] FAIL %s: latency %0d in_ready_seen %0b got %h required latency %0d %h",
                         tbl[i].name, lat, rs, got, W / 4, exp_r);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s1, s2;
        res_t  got, exp_r;
        s1 = mk("b2b_first",  64'd40, 64'd100, 64'd1, 64'd0, OPC_SUB, 2'b10, 0, 0, 0, 4'b0001);
        s2 = mk("b2b_second", 64'd44, 64'h55,  64'hAA, 64'd0, OPC_ORR, 2'b10, 0, 0, 0, 4'b0001);
        @(negedge clk);
        drive(s1);
        @(posedge clk);
        #1 drive(s2);
        @(negedge clk);
        got = observed();
        exp_r = pop_expected();
        tests_run++;
        if (!out_valid || got !== exp_r) begin
            tests_failed++;
            $display("[TB] FAIL %s: valid %0b got %h required %h", s1.name, out_valid, got, exp_r);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        got = observed();
        exp_r = pop_expected();
        tests_run++;
        if (!out_valid || got !== exp_r) begin
            tests_failed++;
            $display("[TB] FAIL %s: valid %0b got %h required %h", s2.name, out_valid, got, exp_r);
        end
    endtask

    task automatic test_stall();
        stim_t s1, s2;
        res_t  got, exp_r, snap;
        int    lat;
        bit    rs;
        s1 = mk("stall_held", 64'd48, 64'd1000, 64'd24, 64'd0, OPC_ADD, 2'b10, 0, 0, 0, 4'b0001);
        s2 = mk("stall_next", 64'd52, 64'd77,   64'd0, 64'd7,  11'd0,   2'b00, 1, 0, 0, 4'b1011);
        @(negedge clk);
        out_ready = 1'b0;
        send(s1);
        @(negedge clk);
        snap = observed();
        exp_r = pop_expected();
        tests_run++;
        if (!out_valid || snap !== exp_r) begin
            tests_failed++;
            $display("[TB] FAIL stall_first: valid %0b got %h required %h", out_valid, snap, exp_r);
        end
        drive(s2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = observed();
            tests_run++;
            if (!out_valid || in_ready !== 1'b0 || got !== snap) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d: valid %0b in_ready %0b got %h required valid 1 in_ready 0 %h",
                         i, out_valid, in_ready, got, snap);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_output(lat, rs);
        got = observed();
        exp_r = pop_expected();
        tests_run++;
        if (!out_valid || lat != 0 || got !== exp_r) begin
            tests_failed++;
            $display("[TB] FAIL %s: latency %0d got %h required latency 0 %h", s2.name, lat, got, exp_r);
        end
    endtask

    task automatic test_reset_mid_mul();
        stim_t s;
        res_t  got, exp_r;
        int    lat;
        bit    rs, seen_valid;
        s = mk("mul_abort", 64'd60, 64'd9, 64'd9, 64'd5, OPC_MUL, 2'b10, 0, 0, 1, 4'b0001);
        @(negedge clk);
        drive(s);
        void'(sb.pop_back());
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        got = observed();
        tests_run++;
        if (out_valid !== 1'b0 || got !== res_t'(0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_mul: valid %0b outputs %h required 0", out_valid, got);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1;
        end
        tests_run++;
        if (seen_valid || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_result: valid_seen %0b in_ready %0b required 0 and 1", seen_valid, in_ready);
        end
        s = mk("after_reset", 64'd64, 64'd2, 64'd3, 64'd0, OPC_ADD, 2'b10, 0, 0, 0, 4'b0001);
        send(s);
        wait_output(lat, rs);
        got = observed();
        exp_r = pop_expected();
        tests_run++;
        if (!out_valid || lat != 0 || got !== exp_r) begin
            tests_failed++;
            $display("[TB] FAIL %s: latency %0d got %h required latency 0 %h", s.name, lat, got, exp_r);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_back_to_back();
        test_stall();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
